// File: rtl/chu_mmio_pkg.sv
// chu_mmio_pkg: shared state encoding and defaults for the MMIO wait-state controller.
// Timeout support in the controller is enabled by defining MMIO_TIMEOUT_EN.
package chu_mmio_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int DEF_N_SLOT  = 64;
  localparam int DEF_SLOT_AW = 6;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

  localparam int WDOG_CW = 16;

  localparam logic [63:0] MMIO_ERR_DATA = '1;

endpackage

// File: rtl/chu_mmio_wdog.sv
// chu_mmio_wdog: saturating wait counter that flags when TIMEOUT cycles elapse.
// Only instantiated by the controller when MMIO_TIMEOUT_EN is defined.
module chu_mmio_wdog
  import chu_mmio_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WDOG_CW-1:0] LIMIT = WDOG_CW'(TIMEOUT);

  logic [WDOG_CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/chu_mmio_ws_controller.sv
// chu_mmio_ws_controller: MMIO slot decoder with per-slot ready wait states.
// Define MMIO_TIMEOUT_EN to add the watchdog that errors out unresponsive slots.
module chu_mmio_ws_controller
  import chu_mmio_pkg::*;
#(
  parameter int N_SLOT  = DEF_N_SLOT,
  parameter int SLOT_AW = DEF_SLOT_AW,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mmio_cs,
  input  logic                      mmio_wr,
  input  logic                      mmio_rd,
  input  logic [SLOT_AW+REG_AW-1:0] mmio_addr,
  input  logic [DW-1:0]             mmio_wr_data,
  output logic [DW-1:0]             mmio_rd_data,
  output logic                      mmio_ready,
  output logic                      mmio_err,
  output logic                      mmio_busy,
  output logic [N_SLOT-1:0]         slot_cs_array,
  output logic [N_SLOT-1:0]         slot_mem_rd_array,
  output logic [N_SLOT-1:0]         slot_mem_wr_array,
  output logic [REG_AW-1:0]         slot_reg_addr,
  output logic [DW-1:0]             slot_wr_data,
  input  logic [N_SLOT*DW-1:0]      slot_rd_data_array,
  input  logic [N_SLOT-1:0]         slot_ready_array
);

  state_t              r_state;
  logic [SLOT_AW-1:0]  r_idx;
  logic                r_wr;
  logic [REG_AW-1:0]   r_reg;
  logic [DW-1:0]       r_wdata;
  logic [DW-1:0]       r_rd_data;
  logic                r_ready;
  logic                r_err;
  logic                r_busy;
  logic [N_SLOT-1:0]   r_cs;
  logic [N_SLOT-1:0]   r_rd_stb;
  logic [N_SLOT-1:0]   r_wr_stb;

  logic [SLOT_AW-1:0]  w_idx;
  logic [REG_AW-1:0]   w_reg;
  logic                w_idx_ok;
  logic                w_accept;
  logic                w_bad;
  logic [N_SLOT-1:0]   w_onehot;
  logic                w_rdy;
  logic [DW-1:0]       w_data;
  logic                w_expired;
  logic                w_wd_clr;
  logic                w_wd_en;

  assign w_idx    = mmio_addr[SLOT_AW+REG_AW-1:REG_AW];
  assign w_reg    = mmio_addr[REG_AW-1:0];
  assign w_idx_ok = ({1'b0, w_idx} < (SLOT_AW+1)'(N_SLOT));
  assign w_accept = (r_state == S_IDLE) && mmio_cs && (mmio_rd || mmio_wr);
  assign w_bad    = !w_idx_ok || (mmio_rd && mmio_wr);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      w_onehot[i] = (w_idx == SLOT_AW'(i));
    end
  end

  // Only the latched slot's ready/data matter; others are ignored.
  always_comb begin
    w_rdy  = 1'b0;
    w_data = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (r_idx == SLOT_AW'(i)) begin
        w_rdy  = slot_ready_array[i];
        w_data = slot_rd_data_array[i*DW +: DW];
      end
    end
  end

  assign w_wd_clr = (r_state == S_IDLE);
  assign w_wd_en  = (r_state == S_STROBE) || (r_state == S_WAIT);

`ifdef MMIO_TIMEOUT_EN
  chu_mmio_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (reset),
    .i_clear   (w_wd_clr),
    .i_en      (w_wd_en),
    .o_expired (w_expired)
  );
`else
  logic w_unused_wd;
  assign w_unused_wd = ^{WDOG_CW'(TIMEOUT), w_wd_clr, w_wd_en};
  assign w_expired   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_wr      <= 1'b0;
      r_reg     <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_cs      <= '0;
      r_rd_stb  <= '0;
      r_wr_stb  <= '0;
    end else begin
      r_cs      <= '0;
      r_rd_stb  <= '0;
      r_wr_stb  <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= w_idx;
            r_wr    <= mmio_wr;
            r_reg   <= w_reg;
            r_wdata <= mmio_wr_data;
            r_busy  <= 1'b1;
            if (w_bad) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_STROBE;
              r_cs    <= w_onehot;
              if (mmio_wr) r_wr_stb <= w_onehot;
              else         r_rd_stb <= w_onehot;
            end
          end
        end
        S_STROBE, S_WAIT: begin
          // Ready beats the watchdog when both land in the same cycle.
          if (w_rdy) begin
            r_state   <= S_RESP;
            r_ready   <= 1'b1;
            r_rd_data <= r_wr ? '0 : w_data;
          end else if (r_state == S_WAIT && w_expired) begin
            r_state   <= S_RESP;
            r_ready   <= 1'b1;
            r_err     <= 1'b1;
            r_rd_data <= DW'(MMIO_ERR_DATA);
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mmio_rd_data      = r_rd_data;
  assign mmio_ready        = r_ready;
  assign mmio_err          = r_err;
  assign mmio_busy         = r_busy;
  assign slot_cs_array     = r_cs;
  assign slot_mem_rd_array = r_rd_stb;
  assign slot_mem_wr_array = r_wr_stb;
  assign slot_reg_addr     = r_reg;
  assign slot_wr_data      = r_wdata;

endmodule

// File: tb/tb_chu_mmio_ws_controller.sv
// tb_chu_mmio_ws_controller: scoreboard bench for the MMIO wait-state controller.
// Timeout cases are exercised when MMIO_TIMEOUT_EN is defined.
module tb_chu_mmio_ws_controller;

  localparam int NS  = 14;
  localparam int SAW = 5;
  localparam int RAW = 5;
  localparam int DW  = 32;
  localparam int TO  = 8;
  localparam int NEVER = 100000;
`ifdef MMIO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 mmio_cs = 1'b0;
  logic                 mmio_wr = 1'b0;
  logic                 mmio_rd = 1'b0;
  logic [SAW+RAW-1:0]   mmio_addr = '0;
  logic [DW-1:0]        mmio_wr_data = '0;
  logic [DW-1:0]        mmio_rd_data;
  logic                 mmio_ready;
  logic                 mmio_err;
  logic                 mmio_busy;
  logic [NS-1:0]        slot_cs_array;
  logic [NS-1:0]        slot_mem_rd_array;
  logic [NS-1:0]        slot_mem_wr_array;
  logic [RAW-1:0]       slot_reg_addr;
  logic [DW-1:0]        slot_wr_data;
  logic [NS*DW-1:0]     slot_rd_data_array = '0;
  logic [NS-1:0]        slot_ready_array = '0;

  chu_mmio_ws_controller #(
    .N_SLOT  (NS),
    .SLOT_AW (SAW),
    .REG_AW  (RAW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .mmio_cs            (mmio_cs),
    .mmio_wr            (mmio_wr),
    .mmio_rd            (mmio_rd),
    .mmio_addr          (mmio_addr),
    .mmio_wr_data       (mmio_wr_data),
    .mmio_rd_data       (mmio_rd_data),
    .mmio_ready         (mmio_ready),
    .mmio_err           (mmio_err),
    .mmio_busy          (mmio_busy),
    .slot_cs_array      (slot_cs_array),
    .slot_mem_rd_array  (slot_mem_rd_array),
    .slot_mem_wr_array  (slot_mem_wr_array),
    .slot_reg_addr      (slot_reg_addr),
    .slot_wr_data       (slot_wr_data),
    .slot_rd_data_array (slot_rd_data_array),
    .slot_ready_array   (slot_ready_array)
  );

  typedef struct {
    int             acc;
    int             cyc;
    logic [DW-1:0]  data;
    logic           err;
    bit             hold;
    logic [RAW-1:0] ra;
    logic [DW-1:0]  wd;
  } rsp_t;

  typedef struct {
    int            cyc;
    logic [NS-1:0] oh;
    bit            wr;
  } stb_t;

  rsp_t rsp_q[$];
  stb_t stb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_busy;
  rsp_t mon_r;
  stb_t mon_s;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every visible DUT output against the scoreboard heads.
  always @(negedge clk) begin
    if (reset) begin
      mon_busy = (rsp_q.size() > 0) && (cyc >= rsp_q[0].acc);
      chk("busy", mmio_busy, mon_busy);
      if (mon_busy && rsp_q[0].hold) begin
        chk("hold_reg_addr", slot_reg_addr, rsp_q[0].ra);
        chk("hold_wr_data", slot_wr_data, rsp_q[0].wd);
      end
      if (|{slot_cs_array, slot_mem_rd_array, slot_mem_wr_array}) begin
        if (stb_q.size() == 0) begin
          chk("stray_strobe",
              {slot_cs_array, slot_mem_rd_array, slot_mem_wr_array}, 0);
        end else begin
          mon_s = stb_q.pop_front();
          chk("stb_cyc", cyc, mon_s.cyc);
          chk("stb_cs", slot_cs_array, mon_s.oh);
          chk("stb_rd", slot_mem_rd_array, mon_s.wr ? '0 : mon_s.oh);
          chk("stb_wr", slot_mem_wr_array, mon_s.wr ? mon_s.oh : '0);
        end
      end
      if (mmio_ready) begin
        if (rsp_q.size() == 0) begin
          chk("stray_ready", mmio_ready, 0);
        end else begin
          mon_r = rsp_q.pop_front();
          chk("rsp_cyc", cyc, mon_r.cyc);
          chk("rsp_data", mmio_rd_data, mon_r.data);
          chk("rsp_err", mmio_err, mon_r.err);
        end
      end
    end
  end

  // Reference model: derives the expected strobe and response from the request.
  task automatic issue(input int idx, input int ra, input bit rd, input bit wr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rdd,
                       input int k, output int a, output bit bad);
    rsp_t r;
    stb_t s;
    for (int i = 0; i < NS; i++) slot_rd_data_array[i*DW +: DW] = $urandom;
    if (idx < NS) slot_rd_data_array[idx*DW +: DW] = rdd;
    mmio_cs      = 1'b1;
    mmio_rd      = rd;
    mmio_wr      = wr;
    mmio_addr    = {SAW'(idx), RAW'(ra)};
    mmio_wr_data = wd;
    a    = cyc + 1;
    bad  = (idx >= NS) || (rd && wr);
    r.acc  = a;
    r.ra   = RAW'(ra);
    r.wd   = wd;
    r.hold = !bad;
    if (bad) begin
      r.cyc  = a;
      r.data = '0;
      r.err  = 1'b1;
    end else begin
      s.cyc = a;
      s.oh  = NS'(1) << idx;
      s.wr  = wr;
      stb_q.push_back(s);
      if (!TO_EN || k <= TO) begin
        r.cyc  = a + 1 + k;
        r.data = wr ? '0 : rdd;
        r.err  = 1'b0;
      end else begin
        r.cyc  = a + 1 + TO;
        r.data = '1;
        r.err  = 1'b1;
      end
    end
    rsp_q.push_back(r);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", mmio_ready, 0);
    chk("rst_err", mmio_err, 0);
    chk("rst_busy", mmio_busy, 0);
    chk("rst_rd_data", mmio_rd_data, 0);
    chk("rst_cs", slot_cs_array, 0);
    chk("rst_rd_stb", slot_mem_rd_array, 0);
    chk("rst_wr_stb", slot_mem_wr_array, 0);
    chk("rst_reg_addr", slot_reg_addr, 0);
    chk("rst_wr_data", slot_wr_data, 0);
    rsp_q.delete();
    stb_q.delete();
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    mmio_wr = 1'b0;
    slot_ready_array = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Slot model plus bus holding: drives ready k cycles after the strobe.
  task automatic serve(input int a, input int idx, input int k, input bit bad,
                       input bit stray);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      slot_ready_array = '0;
      if (stray) slot_ready_array = NS'($urandom) & ~(NS'(1) << idx);
      if (!bad && cyc == a + k) slot_ready_array[idx] = 1'b1;
      if (mmio_ready) begin
        got = 1'b1;
      end else if (cyc >= a && $urandom_range(0, 1) == 1) begin
        mmio_addr    = (SAW+RAW)'($urandom);
        mmio_wr_data = $urandom;
        mmio_rd      = 1'($urandom_range(0, 1));
        mmio_wr      = !mmio_rd;
      end
    end
    mmio_cs = 1'b0;
    mmio_rd = 1'b0;
    mmio_wr = 1'b0;
    slot_ready_array = '0;
    chk("resp_seen", got, 1);
    chk("stb_pending", stb_q.size(), 0);
    if (!got) begin
      @(negedge clk);
      do_reset();
    end
  endtask

  task automatic txn(input int idx, input int ra, input bit rd, input bit wr,
                     input logic [DW-1:0] wd, input logic [DW-1:0] rdd,
                     input int k, input bit stray);
    int a;
    bit bad;
    @(negedge clk);
    issue(idx, ra, rd, wr, wd, rdd, k, a, bad);
    serve(a, idx, k, bad, stray);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int a;
    bit bad;
    int idx;
    int sel;
    @(negedge clk);
    do_reset();

    txn(3, 2, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 0, 1'b0);
    txn(9, 7, 1'b0, 1'b1, 32'hA5A5_0001, 32'h0BAD_0BAD, 4, 1'b0);
    txn(20, 1, 1'b1, 1'b0, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    txn(2, 4, 1'b1, 1'b1, 32'h1111_2222, 32'h3333_4444, 1, 1'b0);
    txn(6, 3, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 6, 1'b1);
    txn(NS-1, 31, 1'b1, 1'b0, 32'h0, 32'h8000_0001, 2, 1'b1);
    txn(NS, 0, 1'b0, 1'b1, 32'h7777_0000, 32'h0, 0, 1'b0);
    txn(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
`ifdef MMIO_TIMEOUT_EN
    txn(4, 5, 1'b1, 1'b0, 32'h0, 32'h0123_4567, NEVER, 1'b0);
    txn(4, 6, 1'b1, 1'b0, 32'h0, 32'h89AB_CDEF, TO, 1'b0);
    txn(7, 6, 1'b0, 1'b1, 32'h4242_4242, 32'h0, TO + 1, 1'b1);
`endif

    // Abandon a pending read on slot 5 with an asynchronous reset.
    @(negedge clk);
    issue(5, 3, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, NEVER, a, bad);
    repeat (4) @(negedge clk);
    chk("wait_busy", mmio_busy, 1);
    do_reset();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      slot_ready_array[5] = 1'b1;
      chk("post_rst_ready", mmio_ready, 0);
      chk("post_rst_cs", slot_cs_array, 0);
    end
    slot_ready_array = '0;

    for (int t = 0; t < 80; t++) begin
      idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31)
                                        : $urandom_range(0, NS - 1);
      sel = $urandom_range(0, 9);
      txn(idx, $urandom_range(0, 31), sel < 6 || sel == 9, sel >= 6,
          $urandom, $urandom, $urandom_range(0, 12),
          1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("final_rsp_q", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
